// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its selector.
package wb_arbiter_pkg;

  localparam int OPID_W         = 16;
  localparam int OPID_VALID_BIT = 15;
  localparam int NPC_W          = 32;
  localparam int PRDA_W         = 7;
  localparam int PRDV_W         = 32;

  // One execution-unit result as seen on a resp lane or a writeback slot.
  typedef struct packed {
    logic [OPID_W-1:0] opid;
    logic [NPC_W-1:0]  npc;
    logic [PRDA_W-1:0] prda;
    logic [PRDV_W-1:0] prdv;
  } exe_bundle_t;

  // A bundle carries a live result only when its opid valid bit is set.
  function automatic logic bundle_valid(input exe_bundle_t b);
    return b.opid[OPID_VALID_BIT];
  endfunction

  // Register-file write is suppressed for results without a destination.
  function automatic logic bundle_writes_rf(input exe_bundle_t b);
    return bundle_valid(b) && (b.prda != {PRDA_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_arbiter_chk.sv
// Protocol checker: units must present results packed from lane 0 upward.
module wb_arbiter_chk #(
  parameter int nfu = 4,
  parameter int ewd = 4
) (
  input logic                      clk,
  input logic                      rst,
  input logic [nfu-1:0][ewd-1:0]   i_valid
);

  logic w_gap;

  // Detect any valid lane sitting above an invalid lane in the same unit.
  always_comb begin
    w_gap = 1'b0;
    for (int u = 0; u < nfu; u++) begin
      for (int j = 1; j < ewd; j++) begin
        if (i_valid[u][j] && !i_valid[u][j-1]) begin
          w_gap = 1'b1;
        end else begin
          w_gap = w_gap;
        end
      end
    end
  end

  // Flag lane gaps; the arbiter ignores the stranded lanes regardless.
  always @(posedge clk) begin
    if (!rst) begin
      assert (w_gap == 1'b0)
        else $warning("wb_arbiter: valid lane above an invalid lane, mask=%h", i_valid);
    end
  end

endmodule

// File: rtl/wb_arbiter_rr_select.sv
// Rotating selector: walks units from a start unit (wrapping), lanes in
// order, and grants up to W eligible lanes. Purely combinational so the
// issue stage can reuse it with its own eligibility rule.
module rr_select #(
  parameter  int N  = 4,
  parameter  int L  = 4,
  parameter  int W  = 4,
  localparam int NL = N * L,
  localparam int IW = (NL > 1) ? $clog2(NL) : 1,
  localparam int PW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(W) + 1
) (
  input  logic [NL-1:0]         i_elig,
  input  logic [PW-1:0]         i_start,
  output logic [NL-1:0]         o_grant,
  output logic [W-1:0][IW-1:0]  o_idx,
  output logic [CW-1:0]         o_count,
  output logic [PW-1:0]         o_last
);

  logic [PW:0] w_unit;
  int          w_cnt;

  // Visit units start, start+1, ... (explicit wrap) and grant lanes in order until W grants.
  always_comb begin
    o_grant = {NL{1'b0}};
    o_idx   = '0;
    o_count = {CW{1'b0}};
    o_last  = {PW{1'b0}};
    w_unit  = {(PW+1){1'b0}};
    w_cnt   = 0;
    for (int s = 0; s < N; s++) begin
      w_unit = {1'b0, i_start} + (PW+1)'(s);
      // Compare-and-subtract wrap keeps non-power-of-two unit counts correct.
      if (w_unit >= (PW+1)'(N)) begin
        w_unit = w_unit - (PW+1)'(N);
      end else begin
        w_unit = w_unit;
      end
      for (int j = 0; j < L; j++) begin
        if (i_elig[int'(w_unit) * L + j] && (w_cnt < W)) begin
          o_grant[int'(w_unit) * L + j] = 1'b1;
          o_idx[w_cnt]                  = IW'(int'(w_unit) * L + j);
          o_last                        = w_unit[PW-1:0];
          w_cnt                         = w_cnt + 1;
        end else begin
          w_cnt = w_cnt;
        end
      end
    end
    o_count = CW'(w_cnt);
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks up to wwd results per cycle across execution
// units with round-robin fairness, pops them via claim, and registers them
// onto the writeback bus.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int nfu = 4,
  parameter int ewd = 4,
  parameter int wwd = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            stall,
  input  exe_bundle_t [nfu-1:0][ewd-1:0]  resp,
  output logic [nfu-1:0][ewd-1:0]         claim,
  output exe_bundle_t [wwd-1:0]           wb,
  output logic [wwd-1:0]                  wb_wena,
  output logic [$clog2(wwd):0]            wb_num,
  output logic [$clog2(nfu)-1:0]          rr_ptr
);

  localparam int NL = nfu * ewd;
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;
  localparam int PW = $clog2(nfu);
  localparam int CW = $clog2(wwd) + 1;

  logic [nfu-1:0][ewd-1:0] w_valid;
  logic [nfu-1:0][ewd-1:0] w_elig;
  logic                    w_run;
  exe_bundle_t [NL-1:0]    w_flat;
  logic [NL-1:0]           w_grant;
  logic [wwd-1:0][IW-1:0]  w_idx;
  logic [CW-1:0]           w_count;
  logic [PW-1:0]           w_last;
  logic [PW-1:0]           w_rr_next;
  logic                    w_claim_en;
  exe_bundle_t [wwd-1:0]   w_slot;
  logic [wwd-1:0]          w_slot_we;

  exe_bundle_t [wwd-1:0]   r_wb;
  logic [wwd-1:0]          r_wena;
  logic [CW-1:0]           r_num;
  logic [PW-1:0]           r_rr;

  assign w_flat = resp;

  // Lane j is a candidate only if it and every lower lane of its unit are valid.
  always_comb begin
    w_valid = '0;
    w_elig  = '0;
    w_run   = 1'b0;
    for (int u = 0; u < nfu; u++) begin
      w_run = 1'b1;
      for (int j = 0; j < ewd; j++) begin
        w_valid[u][j] = bundle_valid(resp[u][j]);
        w_run         = w_run & w_valid[u][j];
        w_elig[u][j]  = w_run;
      end
    end
  end

  rr_select #(
    .N (nfu),
    .L (ewd),
    .W (wwd)
  ) u_sel (
    .i_elig  (w_elig),
    .i_start (r_rr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_count (w_count),
    .o_last  (w_last)
  );

  assign w_claim_en = ~stall & ~flush & ~rst;
  assign claim      = w_grant & {NL{w_claim_en}};

  // Route grant k to slot k; unused slots are zeroed.
  always_comb begin
    w_slot    = '0;
    w_slot_we = {wwd{1'b0}};
    for (int k = 0; k < wwd; k++) begin
      if (CW'(k) < w_count) begin
        w_slot[k]    = w_flat[w_idx[k]];
        w_slot_we[k] = bundle_writes_rf(w_flat[w_idx[k]]);
      end else begin
        w_slot[k]    = '0;
        w_slot_we[k] = 1'b0;
      end
    end
  end

  // Next start unit is the one after the last granted unit, wrapped by compare.
  always_comb begin
    if (w_last == PW'(nfu - 1)) begin
      w_rr_next = {PW{1'b0}};
    end else begin
      w_rr_next = w_last + PW'(1);
    end
  end

  // Single output register stage plus the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wb   <= '0;
      r_wena <= {wwd{1'b0}};
      r_num  <= {CW{1'b0}};
      r_rr   <= {PW{1'b0}};
    end else if (stall) begin
      r_wb   <= r_wb;
      r_wena <= r_wena;
      r_num  <= r_num;
      r_rr   <= r_rr;
    end else begin
      r_wb   <= w_slot;
      r_wena <= w_slot_we;
      r_num  <= w_count;
      if (w_count != {CW{1'b0}}) begin
        r_rr <= w_rr_next;
      end else begin
        r_rr <= r_rr;
      end
    end
  end

  assign wb      = r_wb;
  assign wb_wena = r_wena;
  assign wb_num  = r_num;
  assign rr_ptr  = r_rr;

  wb_arbiter_chk #(
    .nfu (nfu),
    .ewd (ewd)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_valid)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, compared against a queue-style reference of the selection rules.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NFU = 4;
  localparam int EWD = 4;
  localparam int WWD = 4;

  logic                            clk;
  logic                            rst;
  logic                            flush;
  logic                            stall;
  exe_bundle_t [NFU-1:0][EWD-1:0]  resp;
  logic [NFU-1:0][EWD-1:0]         claim;
  exe_bundle_t [WWD-1:0]           wb;
  logic [WWD-1:0]                  wb_wena;
  logic [$clog2(WWD):0]            wb_num;
  logic [$clog2(NFU)-1:0]          rr_ptr;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int                       m_rr = 0;
  exe_bundle_t [WWD-1:0]    m_wb = '0;
  logic [WWD-1:0]           m_wena = '0;
  int                       m_num = 0;
  exe_bundle_t [WWD-1:0]    m_sel;
  logic [NFU-1:0][EWD-1:0]  m_grant;
  int                       m_n;
  int                       m_last;

  wb_arbiter #(.nfu(NFU), .ewd(EWD), .wwd(WWD)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .stall   (stall),
    .resp    (resp),
    .claim   (claim),
    .wb      (wb),
    .wb_wena (wb_wena),
    .wb_num  (wb_num),
    .rr_ptr  (rr_ptr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic exe_bundle_t mk(input bit v, input bit zero_prda);
    exe_bundle_t b;
    b.opid = {v, 15'($urandom)};
    b.npc  = 32'($urandom);
    b.prda = zero_prda ? 7'd0 : 7'($urandom_range(1, 127));
    b.prdv = 32'($urandom);
    return b;
  endfunction

  // Candidate list: units from m_rr wrapping, each unit's leading run of
  // valid lanes; the first WWD candidates are granted.
  task automatic model_select();
    int u;
    m_n     = 0;
    m_last  = -1;
    m_grant = '0;
    m_sel   = '0;
    for (int s = 0; s < NFU; s++) begin
      u = (m_rr + s) % NFU;
      for (int j = 0; j < EWD; j++) begin
        if (!resp[u][j].opid[OPID_VALID_BIT]) break;
        if (m_n < WWD) begin
          m_sel[m_n]    = resp[u][j];
          m_grant[u][j] = 1'b1;
          m_n++;
          m_last = u;
        end
      end
    end
  endtask

  task automatic do_cycle(input string tag);
    logic [NFU-1:0][EWD-1:0] exp_claim;
    #1;
    model_select();
    exp_claim = (rst || stall || flush) ? '0 : m_grant;
    chk({tag, ":claim"}, 512'(claim), 512'(exp_claim));
    @(posedge clk);
    if (rst || flush) begin
      m_wb = '0; m_wena = '0; m_num = 0; m_rr = 0;
    end else if (!stall) begin
      m_wb  = m_sel;
      m_num = m_n;
      for (int k = 0; k < WWD; k++)
        m_wena[k] = (k < m_n) && (m_sel[k].prda != 7'd0);
      if (m_n > 0) m_rr = (m_last + 1) % NFU;
    end
    #1;
    chk({tag, ":wb"},      512'(wb),      512'(m_wb));
    chk({tag, ":wb_num"},  512'(wb_num),  512'(m_num));
    chk({tag, ":wb_wena"}, 512'(wb_wena), 512'(m_wena));
    chk({tag, ":rr_ptr"},  512'(rr_ptr),  512'(m_rr));
  endtask

  task automatic clear_resp();
    for (int u = 0; u < NFU; u++)
      for (int j = 0; j < EWD; j++)
        resp[u][j] = mk(1'b0, 1'b0);
  endtask

  initial begin
    exe_bundle_t held0;
    exe_bundle_t e_u0l0, e_u0l1, e_u2l0, e_u2l1;
    int nv;

    // reset with valid traffic present
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    for (int u = 0; u < NFU; u++)
      for (int j = 0; j < EWD; j++)
        resp[u][j] = mk(1'b1, 1'b0);
    do_cycle("reset0");
    do_cycle("reset1");
    rst = 1'b0;

    // unit0 lanes 0,1 and unit2 lanes 0..3: cap at 4 grants
    clear_resp();
    resp[0][0] = mk(1'b1, 1'b0); resp[0][1] = mk(1'b1, 1'b0);
    for (int j = 0; j < EWD; j++) resp[2][j] = mk(1'b1, 1'b0);
    e_u0l0 = resp[0][0]; e_u0l1 = resp[0][1]; e_u2l0 = resp[2][0]; e_u2l1 = resp[2][1];
    do_cycle("tp1");
    chk("tp1:num4",  512'(wb_num), 512'(4));
    chk("tp1:rr3",   512'(rr_ptr), 512'(3));
    chk("tp1:order", 512'(wb), 512'({e_u2l1, e_u2l0, e_u0l1, e_u0l0}));

    // flush while three results are valid
    clear_resp();
    for (int j = 0; j < 3; j++) resp[1][j] = mk(1'b1, 1'b0);
    flush = 1'b1;
    do_cycle("flush");
    chk("flush:rr0",   512'(rr_ptr),  512'(0));
    chk("flush:wena0", 512'(wb_wena), 512'(0));
    flush = 1'b0;

    // fairness: all lanes valid, pointer walks one unit per cycle
    for (int c = 0; c < 5; c++) begin
      for (int u = 0; u < NFU; u++)
        for (int j = 0; j < EWD; j++)
          resp[u][j] = mk(1'b1, 1'b0);
      do_cycle("fair");
      chk("fair:rr", 512'(rr_ptr), 512'((c + 1) % NFU));
    end

    // gap rule: unit1 lane1 valid above invalid lane0
    clear_resp();
    resp[1][1] = mk(1'b1, 1'b0);
    do_cycle("gap");
    chk("gap:num0", 512'(wb_num), 512'(0));

    // stall: load wb, then stall three cycles with new results, then release
    clear_resp();
    resp[0][0] = mk(1'b1, 1'b0);
    do_cycle("prestall");
    held0 = resp[0][0];
    clear_resp();
    resp[3][0] = mk(1'b1, 1'b0); resp[3][1] = mk(1'b1, 1'b0); resp[0][0] = mk(1'b1, 1'b0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      do_cycle("stall");
      chk("stall:held", 512'(wb[0]), 512'(held0));
    end
    stall = 1'b0;
    do_cycle("release");
    chk("release:num", 512'(wb_num), 512'(3));

    // stall and flush together: flush wins
    stall = 1'b1; flush = 1'b1;
    do_cycle("stallflush");
    chk("stallflush:num0", 512'(wb_num), 512'(0));
    stall = 1'b0; flush = 1'b0;

    // result without destination register alone in unit3
    clear_resp();
    resp[3][0] = mk(1'b1, 1'b1);
    do_cycle("prda0");
    chk("prda0:num1",  512'(wb_num),  512'(1));
    chk("prda0:wena0", 512'(wb_wena), 512'(0));
    chk("prda0:valid", 512'(wb[0].opid[OPID_VALID_BIT]), 512'(1));

    // random traffic
    for (int c = 0; c < 300; c++) begin
      for (int u = 0; u < NFU; u++) begin
        nv = $urandom_range(0, EWD);
        for (int j = 0; j < EWD; j++)
          resp[u][j] = mk(j < nv, ($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 19) == 0)
          resp[u][$urandom_range(0, EWD - 1)] = mk(1'b1, 1'b0);
      end
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      do_cycle("rand");
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
